// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, geometry helpers and byte-enable decode for the n-way data cache
package dcache_pkg;

   typedef enum logic [1:0] {
      WL_8       = 2'd0,
      WL_16      = 2'd1,
      WL_32      = 2'd2,
      WL_ILLEGAL = 2'd3
   } wordlen_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RESP,
      S_WB,
      S_FILL
   } state_e;

   localparam int BYTE_LANES = 4;
   localparam int WORD_SHIFT = 2;

   typedef struct packed {
      logic [BYTE_LANES-1:0] be;
      logic                  err;
   } be_dec_t;

   function automatic int offset_bits(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 0;
   endfunction

   function automatic int tag_bits(input int addrbits, input int line_words);
      return addrbits - offset_bits(line_words) - WORD_SHIFT;
   endfunction

   function automatic be_dec_t be_decode(input logic [1:0] wordlen, input logic [1:0] lo);
      be_dec_t r;
      r.be  = '0;
      r.err = 1'b0;
      case (wordlen_e'(wordlen))
         WL_8:    r.be = 4'b0001 << lo;
         WL_16:   if (lo[0]) r.err = 1'b1; else r.be = 4'b0011 << lo;
         WL_32:   if (lo != 2'b00) r.err = 1'b1; else r.be = 4'b1111;
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dcache_way.sv
// rtl/dcache_way.sv - one cache line: tag, valid, dirty, saturating age and word array
module dcache_way
   import dcache_pkg::*;
#(
   parameter int DATABITS   = 32,
   parameter int TAGW       = 28,
   parameter int IDXW       = 2,
   parameter int LINE_WORDS = 4,
   parameter int TTLBITS    = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [TAGW-1:0]       lookup_tag,
   output logic                  hit,
   output logic                  line_valid,
   output logic                  line_dirty,
   output logic [TAGW-1:0]       line_tag,
   output logic [TTLBITS-1:0]    age,
   input  logic [IDXW-1:0]       rd_idx,
   output logic [DATABITS-1:0]   rd_data,
   input  logic                  wr_en,
   input  logic [IDXW-1:0]       wr_idx,
   input  logic [BYTE_LANES-1:0] wr_be,
   input  logic [DATABITS-1:0]   wr_data,
   input  logic                  set_dirty,
   input  logic                  clr_dirty,
   input  logic                  fill_done,
   input  logic                  age_clr,
   input  logic                  age_inc
);

   logic [DATABITS-1:0] words [LINE_WORDS];

   assign hit     = line_valid && (line_tag == lookup_tag);
   assign rd_data = words[rd_idx];

   always_ff @(posedge clk) begin
      if (wr_en)
         for (int b = 0; b < BYTE_LANES; b++)
            if (wr_be[b]) words[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
   end

   // A completing fill takes the lookup tag; set_dirty then carries a pending store merge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_valid <= 1'b0;
         line_dirty <= 1'b0;
         line_tag   <= '0;
         age        <= '0;
      end else begin
         if (fill_done) begin
            line_valid <= 1'b1;
            line_tag   <= lookup_tag;
            line_dirty <= set_dirty;
         end else if (clr_dirty) begin
            line_dirty <= 1'b0;
         end else if (set_dirty) begin
            line_dirty <= 1'b1;
         end
         if (age_clr)
            age <= '0;
         else if (age_inc && line_valid && (age != '1))
            age <= age + 1'b1;
      end
   end

endmodule

// File: rtl/dcache_nway.sv
// rtl/dcache_nway.sv - fully-associative write-back data cache with burst fill and dirty write-back
module dcache_nway
   import dcache_pkg::*;
#(
   parameter int ADDRBITS   = 32,
   parameter int DATABITS   = 32,
   parameter int NWAYS      = 4,
   parameter int LINE_WORDS = 4,
   parameter int TTLBITS    = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDRBITS-1:0] dcache_addr,
   input  logic [DATABITS-1:0] dcache_datain,
   input  logic                dcache_rdreq,
   input  logic                dcache_wrreq,
   input  logic [1:0]          dcache_wordlen,
   output logic [DATABITS-1:0] dcache_dataout,
   output logic                dcache_valid,
   output logic                dcache_error,
   output logic [ADDRBITS-1:0] mem_addr,
   output logic [DATABITS-1:0] mem_in,
   input  logic [DATABITS-1:0] mem_out,
   input  logic                mem_valid,
   output logic                mem_rdreq,
   output logic                mem_wrreq,
   output logic [15:0]         mem_burstlen
);

   localparam int OFFW = offset_bits(LINE_WORDS);
   localparam int IDXW = (OFFW > 0) ? OFFW : 1;
   localparam int TAGW = tag_bits(ADDRBITS, LINE_WORDS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LINE_WORDS - 1);

   state_e           state_q, state_d;
   logic [IDXW-1:0]  cnt_q, cnt_d;
   logic [NWAYS-1:0] sel_q, sel_d;
   logic             err_q, err_d;

   logic [TAGW-1:0]  req_tag;
   logic [IDXW-1:0]  req_off;
   be_dec_t          dec;
   logic             is_store;

   logic [NWAYS-1:0]      way_hit, way_valid, way_dirty;
   logic [TAGW-1:0]       way_tag [NWAYS];
   logic [TTLBITS-1:0]    way_age [NWAYS];
   logic [DATABITS-1:0]   way_data [NWAYS];

   logic [NWAYS-1:0]      wr_en, set_dirty, clr_dirty, fill_done, age_clr, age_inc;
   logic [IDXW-1:0]       wr_idx, rd_idx;
   logic [BYTE_LANES-1:0] wr_be;
   logic [DATABITS-1:0]   wr_data, fill_word, sel_data;
   logic [TAGW-1:0]       sel_tag;
   logic [NWAYS-1:0]      victim;
   logic                  vict_dirty;
   logic [TTLBITS:0]      best_key, key;
   int                    vict_idx;

   assign req_tag      = TAGW'(dcache_addr >> (OFFW + WORD_SHIFT));
   assign req_off      = IDXW'((dcache_addr >> WORD_SHIFT) & ADDRBITS'(LINE_WORDS - 1));
   assign dec          = be_decode(dcache_wordlen, dcache_addr[1:0]);
   assign is_store     = dcache_wrreq;
   assign mem_burstlen = 16'(LINE_WORDS);

   for (genvar g = 0; g < NWAYS; g++) begin : g_way
      dcache_way #(
         .DATABITS(DATABITS), .TAGW(TAGW), .IDXW(IDXW),
         .LINE_WORDS(LINE_WORDS), .TTLBITS(TTLBITS)
      ) u_way (
         .clk(clk), .reset_n(reset_n), .lookup_tag(req_tag),
         .hit(way_hit[g]), .line_valid(way_valid[g]), .line_dirty(way_dirty[g]),
         .line_tag(way_tag[g]), .age(way_age[g]),
         .rd_idx(rd_idx), .rd_data(way_data[g]),
         .wr_en(wr_en[g]), .wr_idx(wr_idx), .wr_be(wr_be), .wr_data(wr_data),
         .set_dirty(set_dirty[g]), .clr_dirty(clr_dirty[g]), .fill_done(fill_done[g]),
         .age_clr(age_clr[g]), .age_inc(age_inc[g])
      );
   end

   // Invalid ways outrank every age; strict compare keeps ties on the lowest index.
   always_comb begin
      best_key = '0;
      key      = '0;
      vict_idx = 0;
      for (int i = 0; i < NWAYS; i++) begin
         key = way_valid[i] ? {1'b0, way_age[i]} : '1;
         if (i == 0 || key > best_key) begin
            best_key = key;
            vict_idx = i;
         end
      end
      victim = NWAYS'(1) << vict_idx;
   end

   always_comb begin
      sel_data   = '0;
      sel_tag    = '0;
      vict_dirty = 1'b0;
      for (int i = 0; i < NWAYS; i++) begin
         if (sel_q[i]) begin
            sel_data = sel_data | way_data[i];
            sel_tag  = sel_tag | way_tag[i];
         end
         if (victim[i]) vict_dirty = vict_dirty | way_dirty[i];
      end
   end

   // A store that missed is folded into the fill word as it arrives.
   always_comb begin
      fill_word = mem_out;
      for (int b = 0; b < BYTE_LANES; b++)
         if (is_store && (cnt_q == req_off) && dec.be[b])
            fill_word[8*b +: 8] = dcache_datain[8*b +: 8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      sel_d          = sel_q;
      err_d          = err_q;
      wr_en          = '0;
      wr_idx         = req_off;
      wr_be          = dec.be;
      wr_data        = dcache_datain;
      set_dirty      = '0;
      clr_dirty      = '0;
      fill_done      = '0;
      age_clr        = '0;
      age_inc        = '0;
      rd_idx         = req_off;
      dcache_dataout = '0;
      dcache_valid   = 1'b0;
      dcache_error   = 1'b0;
      mem_addr       = '0;
      mem_in         = '0;
      mem_rdreq      = 1'b0;
      mem_wrreq      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dcache_rdreq || dcache_wrreq) begin
               err_d   = dec.err;
               cnt_d   = '0;
               state_d = S_RESP;
               if (!dec.err) begin
                  sel_d   = (|way_hit) ? way_hit : victim;
                  age_clr = sel_d;
                  age_inc = ~sel_d;
                  if (|way_hit) begin
                     if (is_store) begin
                        wr_en     = way_hit;
                        set_dirty = way_hit;
                     end
                  end else begin
                     state_d = vict_dirty ? S_WB : S_FILL;
                  end
               end
            end
         end
         S_RESP: begin
            dcache_valid = 1'b1;
            dcache_error = err_q;
            if (!err_q) dcache_dataout = sel_data;
            state_d = S_IDLE;
         end
         S_WB: begin
            rd_idx    = cnt_q;
            mem_wrreq = 1'b1;
            mem_addr  = ADDRBITS'(sel_tag) << (OFFW + WORD_SHIFT);
            mem_in    = sel_data;
            if (mem_valid) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  cnt_d     = '0;
                  clr_dirty = sel_q;
                  state_d   = S_FILL;
               end
            end
         end
         S_FILL: begin
            mem_rdreq = 1'b1;
            mem_addr  = ADDRBITS'(req_tag) << (OFFW + WORD_SHIFT);
            wr_idx    = cnt_q;
            wr_be     = '1;
            wr_data   = fill_word;
            if (mem_valid) begin
               wr_en = sel_q;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  cnt_d     = '0;
                  fill_done = sel_q;
                  set_dirty = is_store ? sel_q : '0;
                  state_d   = S_RESP;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_nway.sv
// tb/tb_dcache_nway.sv - directed self-checking bench for dcache_nway
module tb_dcache_nway;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] dcache_addr, dcache_datain, dcache_dataout;
   logic        dcache_rdreq, dcache_wrreq, dcache_valid, dcache_error;
   logic [1:0]  dcache_wordlen;
   logic [31:0] mem_addr, mem_in, mem_out;
   logic        mem_valid, mem_rdreq, mem_wrreq;
   logic [15:0] mem_burstlen;

   int errors = 0;
   int checks = 0;

   logic [31:0] r_data, wb_addr;
   logic [31:0] wb_data [4];
   logic        r_err, r_done, r_pulse_ok, r_rdaddr_ok, r_order_ok, r_both;
   int          r_lat, r_nrd, r_nwr;

   dcache_nway dut (
      .clk(clk), .reset_n(reset_n),
      .dcache_addr(dcache_addr), .dcache_datain(dcache_datain),
      .dcache_rdreq(dcache_rdreq), .dcache_wrreq(dcache_wrreq),
      .dcache_wordlen(dcache_wordlen), .dcache_dataout(dcache_dataout),
      .dcache_valid(dcache_valid), .dcache_error(dcache_error),
      .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out),
      .mem_valid(mem_valid), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
      .mem_burstlen(mem_burstlen)
   );

   always #5 clk = ~clk;

   // Memory image: line 0x100 holds 0xA0..0xA3, each further 0x100 of address adds 0x100 << 8.
   function automatic logic [31:0] fill_word(input logic [31:0] line, input int i);
      return ((line - 32'h100) << 8) + 32'hA0 + 32'(i);
   endfunction

   task automatic do_access(input logic [31:0] a, input logic st, input logic [1:0] wl, input logic [31:0] d);
      logic [31:0] line;
      line = a & ~32'hF;
      r_done = 1'b0; r_lat = 0; r_nrd = 0; r_nwr = 0; r_data = '0; r_err = 1'b0; wb_addr = '0;
      r_rdaddr_ok = 1'b1; r_order_ok = 1'b1; r_both = 1'b0; r_pulse_ok = 1'b1;
      @(negedge clk);
      dcache_addr = a; dcache_wordlen = wl; dcache_datain = d;
      dcache_rdreq = !st; dcache_wrreq = st;
      for (int c = 0; c < 200 && !r_done; c++) begin
         @(negedge clk);
         r_lat++;
         mem_valid = 1'b0;
         if (mem_rdreq && mem_wrreq) r_both = 1'b1;
         if (dcache_valid) begin
            r_done = 1'b1; r_data = dcache_dataout; r_err = dcache_error;
            dcache_rdreq = 1'b0; dcache_wrreq = 1'b0;
         end else if (mem_wrreq) begin
            if (r_nrd != 0) r_order_ok = 1'b0;
            wb_addr = mem_addr;
            if (r_nwr < 4) wb_data[r_nwr] = mem_in;
            r_nwr++; mem_valid = 1'b1;
         end else if (mem_rdreq) begin
            if (mem_addr !== line) r_rdaddr_ok = 1'b0;
            mem_out = fill_word(line, r_nrd);
            r_nrd++; mem_valid = 1'b1;
         end
      end
      mem_valid = 1'b0;
      @(negedge clk);
      if (dcache_valid) r_pulse_ok = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; dcache_addr = '0; dcache_datain = '0; dcache_rdreq = 1'b0; dcache_wrreq = 1'b0;
      dcache_wordlen = 2'd0; mem_out = '0; mem_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({dcache_valid, dcache_error, mem_rdreq, mem_wrreq} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {dcache_valid, dcache_error, mem_rdreq, mem_wrreq}); end
      checks++; if ({dcache_dataout, mem_addr, mem_in} !== 96'h0) begin errors++; $display("FAIL reset_buses: got %h expected 0", {dcache_dataout, mem_addr, mem_in}); end
      checks++; if (mem_burstlen !== 16'd4) begin errors++; $display("FAIL burstlen: got %0d expected 4", mem_burstlen); end
      reset_n = 1'b1;
   endtask

   task automatic test_cold_load;
      do_access(32'h100, 1'b0, 2'd2, 32'h0);
      checks++; if (r_done !== 1'b1) begin errors++; $display("FAIL cold_done: got %b expected 1", r_done); end
      checks++; if (r_nrd !== 4 || r_rdaddr_ok !== 1'b1) begin errors++; $display("FAIL cold_fill: got %0d words addr_ok=%b expected 4 words at 0x100", r_nrd, r_rdaddr_ok); end
      checks++; if (r_nwr !== 0) begin errors++; $display("FAIL cold_nowb: got %0d expected 0", r_nwr); end
      checks++; if (r_data !== 32'hA0 || r_err !== 1'b0) begin errors++; $display("FAIL cold_data: got %h err=%b expected 000000a0 err=0", r_data, r_err); end
      checks++; if (r_pulse_ok !== 1'b1) begin errors++; $display("FAIL cold_pulse: got %b expected 1", r_pulse_ok); end
   endtask

   task automatic test_hit_load;
      do_access(32'h108, 1'b0, 2'd2, 32'h0);
      checks++; if (r_lat !== 1) begin errors++; $display("FAIL hit_latency: got %0d expected 1", r_lat); end
      checks++; if (r_data !== 32'hA2) begin errors++; $display("FAIL hit_data: got %h expected 000000a2", r_data); end
      checks++; if (r_nrd !== 0) begin errors++; $display("FAIL hit_nomem: got %0d expected 0", r_nrd); end
   endtask

   task automatic test_store_byte;
      do_access(32'h101, 1'b1, 2'd0, 32'h0000_5500);
      checks++; if (r_lat !== 1 || r_nrd !== 0) begin errors++; $display("FAIL store_hit: got lat %0d rd %0d expected 1 0", r_lat, r_nrd); end
      do_access(32'h100, 1'b0, 2'd2, 32'h0);
      checks++; if (r_data !== 32'h0000_55A0) begin errors++; $display("FAIL store_merge: got %h expected 000055a0", r_data); end
      checks++; if (r_nwr !== 0) begin errors++; $display("FAIL store_nowb: got %0d expected 0", r_nwr); end
   endtask

   task automatic test_fill_ways;
      do_access(32'h204, 1'b1, 2'd2, 32'hDEAD_BEEF);
      checks++; if (r_nrd !== 4 || r_nwr !== 0) begin errors++; $display("FAIL store_miss: got rd %0d wr %0d expected 4 0", r_nrd, r_nwr); end
      do_access(32'h204, 1'b0, 2'd2, 32'h0);
      checks++; if (r_data !== 32'hDEAD_BEEF || r_nrd !== 0) begin errors++; $display("FAIL store_miss_data: got %h rd %0d expected deadbeef 0", r_data, r_nrd); end
      do_access(32'h300, 1'b0, 2'd2, 32'h0);
      checks++; if (r_data !== 32'h0002_00A0) begin errors++; $display("FAIL fill_way2: got %h expected 000200a0", r_data); end
      do_access(32'h40C, 1'b0, 2'd2, 32'h0);
      checks++; if (r_data !== 32'h0003_00A3) begin errors++; $display("FAIL fill_way3: got %h expected 000300a3", r_data); end
      do_access(32'h100, 1'b0, 2'd2, 32'h0);
      do_access(32'h300, 1'b0, 2'd2, 32'h0);
      do_access(32'h400, 1'b0, 2'd2, 32'h0);
      checks++; if (r_nrd !== 0 || r_lat !== 1) begin errors++; $display("FAIL touch_hit: got rd %0d lat %0d expected 0 1", r_nrd, r_lat); end
   endtask

   task automatic test_errors;
      do_access(32'h103, 1'b0, 2'd1, 32'h0);
      checks++; if (r_lat !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL err_16b: got lat %0d err %b expected 1 1", r_lat, r_err); end
      checks++; if (r_nrd !== 0 || r_nwr !== 0) begin errors++; $display("FAIL err_nomem: got rd %0d wr %0d expected 0 0", r_nrd, r_nwr); end
      do_access(32'h100, 1'b1, 2'd3, 32'h1234_5678);
      checks++; if (r_err !== 1'b1 || r_nrd !== 0 || r_nwr !== 0) begin errors++; $display("FAIL err_wl3: got err %b rd %0d wr %0d expected 1 0 0", r_err, r_nrd, r_nwr); end
      do_access(32'h502, 1'b0, 2'd2, 32'h0);
      checks++; if (r_err !== 1'b1 || r_nrd !== 0) begin errors++; $display("FAIL err_32b: got err %b rd %0d expected 1 0", r_err, r_nrd); end
   endtask

   task automatic test_evict;
      do_access(32'h500, 1'b0, 2'd2, 32'h0);
      checks++; if (r_nwr !== 4 || wb_addr !== 32'h200) begin errors++; $display("FAIL evict_wb: got %0d words at %h expected 4 at 00000200", r_nwr, wb_addr); end
      checks++; if (wb_data[0] !== 32'h0001_00A0 || wb_data[1] !== 32'hDEAD_BEEF || wb_data[2] !== 32'h0001_00A2 || wb_data[3] !== 32'h0001_00A3)
         begin errors++; $display("FAIL evict_data: got %h %h %h %h expected 000100a0 deadbeef 000100a2 000100a3", wb_data[0], wb_data[1], wb_data[2], wb_data[3]); end
      checks++; if (r_order_ok !== 1'b1 || r_both !== 1'b0 || r_nrd !== 4) begin errors++; $display("FAIL evict_order: got order %b both %b rd %0d expected 1 0 4", r_order_ok, r_both, r_nrd); end
      checks++; if (r_data !== 32'h0004_00A0) begin errors++; $display("FAIL evict_fill: got %h expected 000400a0", r_data); end
   endtask

   task automatic test_reset_mid_fill;
      int  nrd;
      logic seen;
      nrd = 0; seen = 1'b0;
      @(negedge clk);
      dcache_addr = 32'h600; dcache_wordlen = 2'd2; dcache_rdreq = 1'b1; dcache_wrreq = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge clk);
         mem_valid = 1'b0;
         if (mem_wrreq) begin
            mem_valid = 1'b1;
         end else if (mem_rdreq) begin
            if (nrd == 2) begin
               seen = 1'b1;
               #1 reset_n = 1'b0;
               #1;
            end else begin
               mem_out = fill_word(32'h600, nrd); mem_valid = 1'b1; nrd++;
            end
         end
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_reach_word2: got %b expected 1", seen); end
      checks++; if ({dcache_valid, dcache_error, mem_rdreq, mem_wrreq} !== 4'b0 || {dcache_dataout, mem_addr, mem_in} !== 96'h0)
         begin errors++; $display("FAIL rst_async: got %b %h expected 0", {dcache_valid, dcache_error, mem_rdreq, mem_wrreq}, {dcache_dataout, mem_addr, mem_in}); end
      dcache_rdreq = 1'b0; mem_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      do_access(32'h600, 1'b0, 2'd2, 32'h0);
      checks++; if (r_nrd !== 4 || r_nwr !== 0 || r_data !== 32'h0005_00A0) begin errors++; $display("FAIL rst_refill: got rd %0d wr %0d data %h expected 4 0 000500a0", r_nrd, r_nwr, r_data); end
      do_access(32'h100, 1'b0, 2'd2, 32'h0);
      checks++; if (r_nrd !== 4 || r_data !== 32'hA0) begin errors++; $display("FAIL rst_lost_dirty: got rd %0d data %h expected 4 000000a0", r_nrd, r_data); end
   endtask

   initial begin
      test_reset;
      test_cold_load;
      test_hit_load;
      test_store_byte;
      test_fill_ways;
      test_errors;
      test_evict;
      test_reset_mid_fill;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
